audio_path_core: RTL and testbench

Parametrised mono audio path: takes raw offset-binary samples from the on-chip ADC wrapper, converts them to two's complement and applies a selectable power-of-two gain. Results are buffered in a small FIFO and serialised as I2S, with the same sample on both channels. Replaces the fixed ×4 glue and the stand-alone I2S transmitter between the ADC and the external DAC. It is the insertion point for the future effects pipeline.

---
 rtl/audio_path_core.sv | 181 ++++++++++++++++++
 tb/tb_audio_path_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_path_core.sv
// audio_path_core: mono audio path from the ADC wrapper to an I2S DAC.
// Offset-binary samples become two's complement, get a power-of-two gain,
// pass through a small FIFO and go out as I2S with the same word in both slots.
// Build option: define AUDIO_PATH_SAT_EN to saturate the gain stage;
// without it the gain stage wraps to the low out_res bits.
module audio_path_core #(
    parameter int clk_mhz    = 50,
    parameter int in_res     = 12,
    parameter int out_res    = 16,
    parameter int fifo_depth = 8,
    parameter int bclk_div   = 16,
    parameter int slot_bits  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [in_res-1:0]             adc_sample,
    input  logic                          adc_valid,
    input  logic [2:0]                    gain_shift,
    input  logic                          mute,
    output logic                          mclk,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(fifo_depth):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    // clk_mhz is informational only; it is folded in with weight zero
    localparam int slot_len  = slot_bits * bclk_div;
    localparam int frame_len = 2 * slot_len + 0 * clk_mhz;
    localparam int fc_w      = $clog2(frame_len);
    localparam int ext_w     = out_res + 8;
    localparam int aw        = $clog2(fifo_depth);
    localparam logic [aw:0] full_count = (aw+1)'(fifo_depth);

`ifdef AUDIO_PATH_SAT_EN
    localparam logic signed [ext_w-1:0] sat_max = {{(ext_w-out_res+1){1'b0}}, {(out_res-1){1'b1}}};
    localparam logic signed [ext_w-1:0] sat_min = {{(ext_w-out_res+1){1'b1}}, {(out_res-1){1'b0}}};

    function automatic logic [out_res-1:0] clamp_word(input logic signed [ext_w-1:0] v);
        if (v > sat_max) return {1'b0, {(out_res-1){1'b1}}};
        if (v < sat_min) return {1'b1, {(out_res-1){1'b0}}};
        return v[out_res-1:0];
    endfunction
`else
    function automatic logic [out_res-1:0] clamp_word(input logic signed [ext_w-1:0] v);
        return v[out_res-1:0];
    endfunction
`endif

    // ---- frame timing ----
    logic [fc_w-1:0] fc;
    logic [fc_w-1:0] fc_nxt;
    logic [fc_w-1:0] ph_nxt;
    logic [fc_w-1:0] k_nxt;
    logic            fc_last;

    assign fc_last = (fc == fc_w'(frame_len - 1));
    assign fc_nxt  = fc_last ? '0 : fc + 1'b1;
    assign ph_nxt  = fc_nxt % fc_w'(bclk_div);
    assign k_nxt   = (fc_nxt / fc_w'(bclk_div)) % fc_w'(slot_bits);

    assign mclk  = fc[1];
    assign bclk  = (fc % fc_w'(bclk_div)) >= fc_w'(bclk_div / 2);
    assign lrclk = (fc >= fc_w'(slot_len));

    // Free-running frame counter; everything on the I2S side derives from it
    always_ff @(posedge clk) begin
        if (rst) fc <= '0;
        else     fc <= fc_nxt;
    end

    // ---- stage 1: offset binary to two's complement, sign-extended ----
    logic signed [in_res-1:0] conv;
    logic signed [ext_w-1:0]  smp_p1;
    logic [2:0]               shift_p1;
    logic                     vld_p1;

    assign conv = {~adc_sample[in_res-1], adc_sample[in_res-2:0]};

    // Capture the converted sample and its gain on the ADC strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            smp_p1   <= '0;
            shift_p1 <= '0;
        end else begin
            vld_p1 <= adc_valid;
            if (adc_valid) begin
                smp_p1   <= {{(ext_w-in_res){conv[in_res-1]}}, conv};
                shift_p1 <= gain_shift;
            end
        end
    end

    // ---- stage 2: gain, clamp, FIFO write ----
    logic signed [ext_w-1:0] shifted_p1;
    logic [out_res-1:0]      wr_word;

    assign shifted_p1 = smp_p1 <<< shift_p1;
    assign wr_word    = clamp_word(shifted_p1);

    logic [out_res-1:0] mem [fifo_depth];
    logic [aw-1:0]      wr_ptr;
    logic [aw-1:0]      rd_ptr;
    logic [aw:0]        count;
    logic               written;
    logic               pop;
    logic               push;
    logic [out_res-1:0] hold;

    // A pop on a full FIFO frees the slot a same-cycle write needs
    assign pop  = fc_last && (count != '0);
    assign push = vld_p1 && ((count != full_count) || pop);
    assign fifo_level = count;

    // FIFO storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

    // FIFO pointers, occupancy, sticky flags and the per-frame holding word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            written   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            hold      <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                written <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (vld_p1 && !push) overflow <= 1'b1;
            if (fc_last && (count == '0) && written) underflow <= 1'b1;
        end
    end

    // ---- serialiser ----
    logic [out_res-1:0] shreg;
    logic               sdata_q;
    logic               slot_start;
    logic               bit_edge;
    logic               in_word;

    assign slot_start = (fc == '0) || (fc == fc_w'(slot_len));
    assign bit_edge   = (ph_nxt == '0);
    assign in_word    = (k_nxt >= fc_w'(1)) && (k_nxt <= fc_w'(out_res));

    // Reload at each slot start, shift out MSB first on bclk falling edges
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            sdata_q <= 1'b0;
        end else begin
            if (slot_start)
                shreg <= hold;
            else if (bit_edge && in_word)
                shreg <= shreg << 1;
            if (bit_edge)
                sdata_q <= in_word ? shreg[out_res-1] : 1'b0;
        end
    end

    // Mute silences the line immediately; the FIFO keeps draining
    assign sdata = sdata_q & ~mute;

endmodule

// File: tb/tb_audio_path_core.sv
// Bench for audio_path_core: random samples, an I2S receiver that rebuilds
// the transmitted words, and a queue-based reference of the expected stream.
`timescale 1ns/1ps
module tb_audio_path_core;

    localparam int IN_RES    = 12;
    localparam int OUT_RES   = 16;
    localparam int DEPTH     = 8;
    localparam int BCLK_DIV  = 16;
    localparam int SLOT_BITS = 32;
    localparam int FRAME     = 2 * SLOT_BITS * BCLK_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IN_RES-1:0] adc_sample = '0;
    logic              adc_valid = 1'b0;
    logic [2:0]        gain_shift = '0;
    logic              mute = 1'b0;
    logic              mclk, bclk, lrclk, sdata, overflow, underflow;
    logic [3:0]        fifo_level;

    always #10 clk = ~clk;

    audio_path_core #(
        .clk_mhz(50), .in_res(IN_RES), .out_res(OUT_RES), .fifo_depth(DEPTH),
        .bclk_div(BCLK_DIV), .slot_bits(SLOT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .adc_sample(adc_sample), .adc_valid(adc_valid),
        .gain_shift(gain_shift), .mute(mute), .mclk(mclk), .bclk(bclk),
        .lrclk(lrclk), .sdata(sdata), .fifo_level(fifo_level),
        .overflow(overflow), .underflow(underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference conversion from plain arithmetic on the sample value
    function automatic logic [15:0] ref_word(input logic [11:0] s, input logic [2:0] g);
        longint v;
        v = (longint'(s) - 2048) * (longint'(1) << g);
`ifdef AUDIO_PATH_SAT_EN
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    // Reference model and I2S receiver state
    logic [15:0] exp_q[$];
    logic [15:0] hold_m;
    logic [15:0] rx_word;
    bit          written_m, ovf_m, unf_m;
    bit          prev_bclk, prev_lr, rx_lr, pad_bad;
    int          bitidx;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_m = '0; written_m = 0; ovf_m = 0; unf_m = 0;
            prev_bclk = 0; prev_lr = 0; rx_lr = 1; bitidx = 0;
            rx_word = '0; pad_bad = 0;
        end else begin
            if (adc_valid) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(ref_word(adc_sample, gain_shift));
                    written_m = 1;
                end else begin
                    ovf_m = 1;
                end
            end
            if (prev_lr && !lrclk) begin
                if (exp_q.size() > 0) hold_m = exp_q.pop_front();
                else if (written_m)   unf_m = 1;
            end
            if (bclk && !prev_bclk) begin
                if (lrclk != rx_lr) begin
                    rx_lr = lrclk; bitidx = 0; rx_word = '0; pad_bad = 0;
                end else begin
                    bitidx++;
                end
                if (bitidx >= 1 && bitidx <= OUT_RES) rx_word = {rx_word[14:0], sdata};
                else if (sdata) pad_bad = 1;
                if (bitidx == OUT_RES)
                    check_val(rx_lr ? "word_right" : "word_left", rx_word, mute ? 16'h0 : hold_m);
                if (bitidx == SLOT_BITS - 1)
                    check_val("slot_padding", pad_bad, 0);
            end
            if (mute) check_val("mute_sdata", sdata, 0);
            prev_bclk = bclk;
            prev_lr   = lrclk;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_lr(input logic from_lvl, input string tag);
        logic p;
        p = lrclk;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (p == from_lvl && lrclk == !from_lvl) return;
            p = lrclk;
        end
        check_val(tag, 0, 1);
    endtask

    task automatic wait_frame();  wait_lr(1'b1, "timeout_frame"); endtask
    task automatic wait_right();  wait_lr(1'b0, "timeout_right"); endtask

    task automatic strobe(input logic [11:0] s, input logic [2:0] g);
        adc_sample = s; gain_shift = g; adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic check_zero_outputs();
        check_val("rst_mclk", mclk, 0);
        check_val("rst_bclk", bclk, 0);
        check_val("rst_lrclk", lrclk, 0);
        check_val("rst_sdata", sdata, 0);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_underflow", underflow, 0);
    endtask

    task automatic check_flags();
        check_val("fifo_level", fifo_level, exp_q.size());
        check_val("overflow", overflow, ovf_m);
        check_val("underflow", underflow, unf_m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check_zero_outputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // No writes since reset: underflow must stay clear
        wait_frame(); wait_frame(); tick(4);
        check_flags();

        // Full-scale positive and negative at gain 0, then gain 5, then underflow
        wait_right(); strobe(12'hFFF, 3'd0);
        wait_frame(); wait_right(); strobe(12'h000, 3'd0); tick(3); check_flags();
        wait_frame(); wait_right(); strobe(12'hFFF, 3'd5);
        wait_frame(); wait_right(); strobe(12'h000, 3'd5);
        wait_frame(); wait_frame(); wait_frame(); wait_right();
        check_flags();

        // Ten back-to-back strobes: FIFO fills, two dropped, drains in order
        do_reset();
        wait_right();
        for (int i = 0; i < 10; i++) strobe(12'($urandom), 3'($urandom_range(0, 7)));
        tick(3);
        check_flags();
        repeat (9) wait_frame();
        wait_right();
        check_flags();

        // Mute with a non-empty FIFO: silent line, occupancy still drops each frame
        do_reset();
        wait_right();
        for (int i = 0; i < 4; i++) strobe(12'($urandom), 3'($urandom_range(0, 3)));
        wait_frame();
        mute = 1'b1;
        repeat (3) begin
            wait_right(); check_flags();
            wait_frame();
        end
        mute = 1'b0;

        // Random traffic with occasional muted frames
        repeat (12) begin
            wait_right();
            repeat ($urandom_range(0, 3)) strobe(12'($urandom), 3'($urandom_range(0, 7)));
            tick(3);
            check_flags();
            wait_frame();
            mute = ($urandom_range(0, 3) == 0);
        end
        mute = 1'b0;

        // Reset in the middle of a frame: outputs drop at once, next frame is zeros
        wait_frame();
        tick(299);
        rst = 1'b1;
        tick();
        check_zero_outputs();
        rst = 1'b0;
        wait_frame(); wait_right();
        check_flags();
        tick(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
